// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select codes and the per-stage control bundle driven to the pipeline registers.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MWAIT = 2'b01,
        ERR   = 2'b10
    } state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
        logic exmem_flush;
        logic memwb_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0,
        exmem_hold: 1'b0, exmem_flush: 1'b0, memwb_bubble: 1'b0
    };

    localparam stage_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1,
        exmem_hold: 1'b0, exmem_flush: 1'b0, memwb_bubble: 1'b1
    };

    // Everything frozen; both bubbles keep junk from reaching EX or WB.
    localparam stage_ctrl_t CTRL_ERR = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1,
        exmem_hold: 1'b1, exmem_flush: 1'b0, memwb_bubble: 1'b1
    };

    // ID/EX is frozen by the held EX/MEM downstream, so it is not bubbled here.
    localparam stage_ctrl_t CTRL_MEM_STALL = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0,
        exmem_hold: 1'b1, exmem_flush: 1'b0, memwb_bubble: 1'b1
    };

    localparam stage_ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1,
        exmem_hold: 1'b0, exmem_flush: 1'b1, memwb_bubble: 1'b0
    };

    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1,
        exmem_hold: 1'b0, exmem_flush: 1'b0, memwb_bubble: 1'b0
    };

    // A producer only counts if it writes a real register ($0 is hardwired).
    function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                     input logic             regwrite,
                                     input logic [REG_W-1:0] rs);
        return regwrite && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding select for one ALU operand; the youngest producer (EX/MEM) wins
// over MEM/WB when both target the same source register.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_rs,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             memwb_regwrite,
    output logic [1:0]       fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_hit(exmem_rd, exmem_regwrite, src_rs)) begin
            fwd_sel = FWD_EXMEM;
        end else if (reg_hit(memwb_rd, memwb_regwrite, src_rs)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five pipeline registers: per-stage hold/flush/bubble,
// EX operand forwarding and the data-memory wait handshake with timeout watchdog.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rs,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwrite,
    input  logic             exmem_memop,
    input  logic             exmem_br_taken,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             memwb_regwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             bus_err,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  STALL_MAX  = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0] wait_inc;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              bus_err_q, bus_err_d;

    logic              mem_stall;
    logic              load_use;
    stage_ctrl_t       ctrl;
    logic [1:0]        fwd_a_sel, fwd_b_sel;

    assign mem_stall = (state_q != ERR) && exmem_memop && !dmem_ready;
    assign load_use  = idex_memread && (idex_rt != '0) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    assign wait_inc  = wait_cnt_q + WAIT_W'(1);

    pipe_fwd_unit u_fwd_a (
        .src_rs         (idex_rs),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .fwd_sel        (fwd_a_sel)
    );

    pipe_fwd_unit u_fwd_b (
        .src_rs         (idex_rt),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .fwd_sel        (fwd_b_sel)
    );

    // Stage-control priority: reset > ERR > memory stall > branch > load-use > normal.
    always_comb begin
        ctrl = CTRL_NORMAL;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (state_q == ERR) begin
            ctrl = CTRL_ERR;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM_STALL;
        end else if (exmem_br_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    // wait_cnt counts request cycles without ready, the first RUN cycle being 1.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MWAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MWAIT: begin
                if (mem_stall) begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= WAIT_LIMIT) begin
                        state_d   = ERR;
                        bus_err_d = 1'b1;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_write && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_hold   = ctrl.exmem_hold;
    assign exmem_flush  = ctrl.exmem_flush;
    assign memwb_bubble = ctrl.memwb_bubble;

    assign dmem_req  = rst_n && (state_q != ERR) && exmem_memop;
    assign fwd_a     = rst_n ? fwd_a_sel : FWD_REG;
    assign fwd_b     = rst_n ? fwd_b_sel : FWD_REG;
    assign stall_cnt = stall_cnt_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;

endmodule
